tap_controller: RTL
===================

# tap_controller

IEEE 1149.1-style TAP controller and instruction decoder that directly drives the boundary-scan cell chain. It tracks the 16-state TAP FSM from TMS and holds a 4-bit instruction register. It generates the CaptureDR/ShiftDR/UpdateDR/TestMode controls consumed by every boundary-scan cell, and muxes the selected data register onto TDO. It sits between the JTAG pins and the first/last boundary-scan cells.

## Interface
- IDCODE_VALUE, 32'h1000_0001, device ID word; bit 0 must be 1.
- TCK  in  1  test clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; sampled on rising TCK.
- TMS  in  1  test mode select.
- TDI  in  1  serial data in; also drives FromPreviousBSCell of first cell externally.
- BSChainOut  in  1  ToNextBSCell of last boundary-scan cell.
- TDO  out  1  serial data out (combinational mux).
- TDOEnable  out  1  high in Shift-DR or Shift-IR.
- CaptureDR  out  1  to all cells; gated by instruction.
- ShiftDR  out  1  to all cells; gated by instruction.
- UpdateDR  out  1  to all cells; gated by instruction.
- TestMode  out  1  to all cells; 1 when Instruction = EXTEST.
- TAPState  out  4  current FSM state code.
- Instruction  out  4  active (updated) instruction.

## Operation
- State codes: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions (TMS=0 / TMS=1): TLR→RTI/TLR; RTI→RTI/SelDR; SelDR→CapDR/SelIR; CapDR→ShDR/Ex1DR; ShDR→ShDR/Ex1DR; Ex1DR→PauseDR/UpdDR; PauseDR→PauseDR/Ex2DR; Ex2DR→ShDR/UpdDR; UpdDR→RTI/SelDR; SelIR→CapIR/TLR; IR branch mirrors DR; UpdIR→RTI/SelDR.
- Five consecutive TMS=1 from any state reach TLR.
- Opcodes: EXTEST 4'b0000, IDCODE 4'b0001, BYPASS 4'b1111; every other code decodes as BYPASS.
- IR shift register (4 bits): CapIR loads 4'b0001. ShIR shifts right, TDI into bit 3, bit 0 is TDO. UpdIR copies it to Instruction.
- Instruction reset value (Reset or state TLR): IDCODE if TAP_IDCODE_EN, else BYPASS.
- Bypass register (1 bit): CapDR loads 0; ShDR loads TDI; only when BYPASS selected.
- ID register (32 bits): CapDR loads IDCODE_VALUE. ShDR shifts right with TDI into bit 31. Only when IDCODE selected.
- CaptureDR/ShiftDR/UpdateDR = (state == CapDR/ShDR/UpdDR) AND (Instruction == EXTEST); else 0.
- TDO: ShIR→IR shift bit 0; ShDR+EXTEST→BSChainOut; ShDR+IDCODE→ID bit 0; ShDR+BYPASS→bypass bit; otherwise 0.

## Timing
- Reset values: state F; TAPState 4'hF; Instruction per reset rule; TestMode 0; CaptureDR/ShiftDR/UpdateDR/TDOEnable 0; TDO 0; IR shift 4'b0001; bypass 0.
- Reset has priority over TMS on the same edge. Reset mid-shift discards partial IR/DR contents and leaves Instruction at its reset value.
- FSM and registers update on rising TCK. Strobes are Moore decodes of the state register: each is high for exactly the cycle the FSM occupies that state. Cells act on the rising edge that ends the state.
- Instruction, and therefore TestMode, changes on the rising edge leaving UpdIR. Effect is visible in the next cycle (RTI or SelDR).
- Instruction is stable throughout the DR branch; no mid-scan instruction change.
- TDO is combinational and valid within the same cycle as the state; DR/IR bit N appears after N shift edges.

## Configuration
- TAP_IDCODE_EN defined: 32-bit ID register present; IDCODE opcode selects it; reset instruction is IDCODE.
- Not defined: ID register absent; opcode 4'b0001 decodes as BYPASS; reset instruction is BYPASS.

## Test plan
- Reset high 1 cycle, TMS=1 → TAPState F, TestMode 0, Instruction 4'b0001 (EN) or 4'b1111, all strobes 0.
- From TLR, TMS 0,1,0,0 → states C,7,6,2; with EXTEST loaded, CaptureDR high exactly in state 6, ShiftDR high in state 2.
- IR scan: TMS to ShIR, shift TDI 0,0,0,0, Ex1IR, UpdIR → TDO during shift shows 1,0,0,0; Instruction 4'b0000 and TestMode 1 from next cycle.
- BYPASS: load 4'b1111, shift TDI 1,0,1,1 in ShDR → TDO 0,1,0,1; all cell strobes stay 0.
- IDCODE (EN, IDCODE_VALUE 32'h1000_0001): after reset, 32 shifts → TDO outputs 32'h1000_0001 LSB first.
- In ShDR, TMS=1 five cycles → TAPState F, Instruction back to reset value, TestMode 0; Reset asserted in ShIR → TAPState F next cycle.

Source files
------------

// File: rtl/tap_controller.sv
// tap_controller: JTAG TAP state machine, 4-bit instruction register and
// data-register mux. It drives the shared control strobes of the boundary-scan
// cell chain.
//
// Optional feature macro: TAP_IDCODE_EN. When it is defined, the 32-bit ID
// register exists and the reset instruction is IDCODE. When it is undefined,
// opcode 4'b0001 decodes as BYPASS and the reset instruction is BYPASS.
//
// Ports:
//   TCK          test clock; all state changes on its rising edge
//   Reset        synchronous active-high reset
//   TMS, TDI     JTAG mode select and serial data in
//   BSChainOut   serial output of the last boundary-scan cell
//   TDO          serial data out (combinational)
//   TDOEnable    high in Shift-DR / Shift-IR
//   CaptureDR, ShiftDR, UpdateDR, TestMode   boundary-cell controls (EXTEST only)
//   TAPState     current FSM state code
//   Instruction  active instruction
module tap_controller #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic       TCK,
    input  logic       Reset,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSChainOut,
    output logic       TDO,
    output logic       TDOEnable,
    output logic       CaptureDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       TestMode,
    output logic [3:0] TAPState,
    output logic [3:0] Instruction
);

    typedef enum logic [3:0] {
        StExit2Dr  = 4'h0,
        StExit1Dr  = 4'h1,
        StShiftDr  = 4'h2,
        StPauseDr  = 4'h3,
        StSelIr    = 4'h4,
        StUpdDr    = 4'h5,
        StCapDr    = 4'h6,
        StSelDr    = 4'h7,
        StExit2Ir  = 4'h8,
        StExit1Ir  = 4'h9,
        StShiftIr  = 4'hA,
        StPauseIr  = 4'hB,
        StRti      = 4'hC,
        StUpdIr    = 4'hD,
        StCapIr    = 4'hE,
        StTlr      = 4'hF
    } tap_state_e;

    localparam logic [3:0] OpExtest = 4'b0000;
    localparam logic [3:0] OpBypass = 4'b1111;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] OpIdcode   = 4'b0001;
    localparam logic [3:0] ResetInstr = OpIdcode;
`else
    localparam logic [3:0] ResetInstr = OpBypass;
`endif

    tap_state_e state_q, state_d;
    logic [3:0] ir_q, ir_d;
    logic [3:0] instr_q, instr_d;
    logic       byp_q, byp_d;
`ifdef TAP_IDCODE_EN
    logic [31:0] id_q, id_d;
`endif

    logic sel_extest, sel_idcode, sel_bypass;

    assign sel_extest = (instr_q == OpExtest);
`ifdef TAP_IDCODE_EN
    assign sel_idcode = (instr_q == OpIdcode);
`else
    assign sel_idcode = 1'b0;
`endif
    // Every opcode that is not otherwise decoded selects the bypass register.
    assign sel_bypass = !sel_extest && !sel_idcode;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:     state_d = TMS ? StTlr     : StRti;
            StRti:     state_d = TMS ? StSelDr   : StRti;
            StSelDr:   state_d = TMS ? StSelIr   : StCapDr;
            StCapDr:   state_d = TMS ? StExit1Dr : StShiftDr;
            StShiftDr: state_d = TMS ? StExit1Dr : StShiftDr;
            StExit1Dr: state_d = TMS ? StUpdDr   : StPauseDr;
            StPauseDr: state_d = TMS ? StExit2Dr : StPauseDr;
            StExit2Dr: state_d = TMS ? StUpdDr   : StShiftDr;
            StUpdDr:   state_d = TMS ? StSelDr   : StRti;
            StSelIr:   state_d = TMS ? StTlr     : StCapIr;
            StCapIr:   state_d = TMS ? StExit1Ir : StShiftIr;
            StShiftIr: state_d = TMS ? StExit1Ir : StShiftIr;
            StExit1Ir: state_d = TMS ? StUpdIr   : StPauseIr;
            StPauseIr: state_d = TMS ? StExit2Ir : StPauseIr;
            StExit2Ir: state_d = TMS ? StUpdIr   : StShiftIr;
            StUpdIr:   state_d = TMS ? StSelDr   : StRti;
        endcase
    end

    always_comb begin
        ir_d    = ir_q;
        instr_d = instr_q;
        byp_d   = byp_q;
`ifdef TAP_IDCODE_EN
        id_d    = id_q;
`endif
        case (state_q)
            StCapIr:   ir_d = 4'b0001;
            StShiftIr: ir_d = {TDI, ir_q[3:1]};
            StUpdIr:   instr_d = ir_q;
            StCapDr: begin
                if (sel_bypass) byp_d = 1'b0;
`ifdef TAP_IDCODE_EN
                if (sel_idcode) id_d = IDCODE_VALUE;
`endif
            end
            StShiftDr: begin
                if (sel_bypass) byp_d = TDI;
`ifdef TAP_IDCODE_EN
                if (sel_idcode) id_d = {TDI, id_q[31:1]};
`endif
            end
            default: ;
        endcase
        // Load the reset instruction on the edge that enters TLR, so it is
        // already active in the first TLR cycle.
        if (state_d == StTlr) instr_d = ResetInstr;
    end

    always_ff @(posedge TCK) begin
        if (Reset) begin
            state_q <= StTlr;
            ir_q    <= 4'b0001;
            instr_q <= ResetInstr;
            byp_q   <= 1'b0;
`ifdef TAP_IDCODE_EN
            id_q    <= IDCODE_VALUE;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            instr_q <= instr_d;
            byp_q   <= byp_d;
`ifdef TAP_IDCODE_EN
            id_q    <= id_d;
`endif
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state_q == StShiftIr) begin
            TDO = ir_q[0];
        end else if (state_q == StShiftDr) begin
            if (sel_extest)      TDO = BSChainOut;
`ifdef TAP_IDCODE_EN
            else if (sel_idcode) TDO = id_q[0];
`endif
            else                 TDO = byp_q;
        end
    end

    assign TDOEnable   = (state_q == StShiftDr) || (state_q == StShiftIr);
    assign CaptureDR   = (state_q == StCapDr)   && sel_extest;
    assign ShiftDR     = (state_q == StShiftDr) && sel_extest;
    assign UpdateDR    = (state_q == StUpdDr)   && sel_extest;
    assign TestMode    = sel_extest;
    assign TAPState    = state_q;
    assign Instruction = instr_q;

endmodule
